// File: rtl/fetch_controller.sv
// Instruction fetch controller: fetch PC plus a 2-entry prefetch buffer
// that decouples instruction memory from the decode stage.
module fetch_controller (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [1:0]  buf_count
);

    logic [31:0] fetch_pc;
    logic [31:0] pc_mem [2];
    logic [31:0] instr_mem [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;
    logic        push;
    logic        pop;
    logic        unused_bits;

    // Redirect targets are word aligned; the low bits are ignored.
    assign unused_bits = ^branch_addr[1:0];

    assign pop  = (count != 2'd0) & out_ready;
    assign push = ~branch_taken & ((count != 2'd2) | pop);

    assign imem_addr = fetch_pc;
    assign out_valid = (count != 2'd0);
    assign out_pc    = pc_mem[rd_ptr];
    assign out_instr = instr_mem[rd_ptr];
    assign buf_count = count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= 32'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count    <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                pc_mem[i]    <= 32'd0;
                instr_mem[i] <= 32'd0;
            end
        end else if (branch_taken) begin
            fetch_pc <= {branch_addr[31:2], 2'b00};
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count    <= 2'd0;
        end else begin
            if (push) begin
                pc_mem[wr_ptr]    <= fetch_pc;
                instr_mem[wr_ptr] <= imem_instr;
                wr_ptr            <= ~wr_ptr;
                fetch_pc          <= fetch_pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller: stimulus queues expected
// {pc, instr} pairs, a negedge monitor checks every delivery.
module tb_fetch_controller;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [1:0]  buf_count;

    int checks;
    int failures;
    int delivered;
    int d0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } item_t;

    item_t exp_q[$];

    fetch_controller dut (
        .clk(clk),
        .rst(rst),
        .imem_addr(imem_addr),
        .imem_instr(imem_instr),
        .branch_taken(branch_taken),
        .branch_addr(branch_addr),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_instr(out_instr),
        .out_pc(out_pc),
        .buf_count(buf_count)
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h10)
            return 32'd0;
        return (a * 32'h9E37) ^ 32'h5A5A_0001;
    endfunction

    assign imem_instr = mem(imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_from(input logic [31:0] start);
        logic [31:0] a;
        item_t it;
        exp_q.delete();
        a = start;
        for (int i = 0; i < 48; i++) begin
            it.pc    = a;
            it.instr = mem(a);
            exp_q.push_back(it);
            a = a + 32'd4;
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            item_t e;
            delivered++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_empty got_pc=%h exp=none", out_pc);
            end else begin
                e = exp_q.pop_front();
                check("sb_pc", out_pc, e.pc);
                check("sb_instr", out_instr, e.instr);
            end
        end
    end

    initial begin
        checks       = 0;
        failures     = 0;
        delivered    = 0;
        rst          = 1'b1;
        out_ready    = 1'b1;
        branch_taken = 1'b0;
        branch_addr  = 32'd0;
        tick();
        tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(buf_count), 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        check("rst_pc", out_pc, 32'd0);
        check("rst_instr", out_instr, 32'd0);

        // streaming from reset, one per cycle
        rst = 1'b0;
        expect_from(32'd0);
        d0 = delivered;
        tick();
        check("first_valid", 32'(out_valid), 32'd1);
        check("first_pc", out_pc, 32'd0);
        for (int i = 0; i < 8; i++) tick();
        check("stream_cnt", 32'(delivered - d0), 32'd8);
        check("stream_pc", out_pc, 32'h20);

        // freeze after reset, then drain
        rst = 1'b1;
        out_ready = 1'b0;
        tick();
        rst = 1'b0;
        expect_from(32'd0);
        for (int i = 0; i < 5; i++) tick();
        check("frz_count", 32'(buf_count), 32'd2);
        check("frz_addr", imem_addr, 32'h8);
        check("frz_pc", out_pc, 32'd0);
        d0 = delivered;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("drain_cnt", 32'(delivered - d0), 32'd4);
        check("drain_pc", out_pc, 32'h10);

        // branch with a full buffer
        out_ready = 1'b0;
        tick();
        tick();
        check("pre_br_count", 32'(buf_count), 32'd2);
        branch_taken = 1'b1;
        branch_addr  = 32'h43;
        tick();
        branch_taken = 1'b0;
        expect_from(32'h40);
        check("br_valid", 32'(out_valid), 32'd0);
        check("br_count", 32'(buf_count), 32'd0);
        check("br_addr", imem_addr, 32'h40);
        tick();
        check("br_pc", out_pc, 32'h40);
        check("br_valid2", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        tick();
        tick();

        // back-to-back redirects, last wins
        branch_taken = 1'b1;
        branch_addr  = 32'h100;
        tick();
        check("bb_valid1", 32'(out_valid), 32'd0);
        branch_addr = 32'h206;
        tick();
        check("bb_valid2", 32'(out_valid), 32'd0);
        check("bb_addr", imem_addr, 32'h204);
        branch_taken = 1'b0;
        expect_from(32'h204);
        tick();
        check("bb_pc", out_pc, 32'h204);
        tick();

        // wrap at the top of the address space
        branch_taken = 1'b1;
        branch_addr  = 32'hFFFF_FFFC;
        tick();
        branch_taken = 1'b0;
        expect_from(32'hFFFF_FFFC);
        tick();
        check("wrap_pc0", out_pc, 32'hFFFF_FFFC);
        tick();
        check("wrap_pc1", out_pc, 32'h0);

        // alternating ready
        d0 = delivered;
        for (int i = 0; i < 20; i++) begin
            out_ready = (i % 2 == 0);
            tick();
        end
        check("alt_cnt", 32'(delivered - d0), 32'd10);

        // asynchronous reset with a full buffer
        out_ready = 1'b0;
        tick();
        tick();
        check("ar_pre_count", 32'(buf_count), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check("ar_valid", 32'(out_valid), 32'd0);
        check("ar_count", 32'(buf_count), 32'd0);
        check("ar_addr", imem_addr, 32'd0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        expect_from(32'd0);
        d0 = delivered;
        tick();
        check("ar_pc", out_pc, 32'd0);
        for (int i = 0; i < 4; i++) tick();
        check("ar_cnt", 32'(delivered - d0), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset. The clock port is clk and the reset port is rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 imem_addr  output  32  byte address driven to the instruction memory; always equals fetch_pc.
REQ-005 imem_instr  input  32  instruction word returned combinationally for imem_addr in the same cycle.
REQ-006 branch_taken  input  1  redirect request from the execute stage; sampled at the clock edge.
REQ-007 branch_addr  input  32  redirect target byte address.
REQ-008 out_ready  input  1  decode stage can accept (low = freeze).
REQ-009 out_valid  output  1  head of the prefetch buffer is valid.
REQ-010 out_instr  output  32  instruction word at the buffer head.
REQ-011 out_pc  output  32  byte address of out_instr.
REQ-012 buf_count  output  2  number of occupied buffer entries (0..2).

Function
REQ-013 SHALL hold a 32-bit fetch_pc register and a 2-entry FIFO of {pc, instr} pairs with read pointer, write pointer and count.
REQ-014 SHALL define pop = out_valid & out_ready.
REQ-015 SHALL define push = !branch_taken & (count<2 | pop).
REQ-016 On push, SHALL write {fetch_pc, imem_instr} at the tail and set fetch_pc <= fetch_pc+4 at the same edge.
REQ-017 On pop, SHALL advance the head. Simultaneous push and pop SHALL leave count unchanged, with no loss or duplication, including when count=2.
REQ-018 SHALL drive out_valid = (count!=0), and out_instr/out_pc directly from the head entry with no combinational path from imem_instr.
REQ-019 Latency: an instruction fetched at edge N SHALL appear on out_* after edge N; sustained throughput SHALL be 1 instruction/cycle while out_ready=1.
REQ-020 While out_ready=0, SHALL fill to count=2 and then hold fetch_pc, imem_addr and all buffer contents stable.
REQ-021 On an edge with branch_taken=1, SHALL clear count and both pointers, and set fetch_pc <= {branch_addr[31:2],2'b00}. No push SHALL occur on that edge.
REQ-022 branch_taken SHALL take priority over pop and push on the same edge. A head consumed on that edge counts as delivered.
REQ-023 fetch_pc+4 SHALL wrap modulo 2^32 (0xFFFFFFFC -> 0x00000000) with no flag.
REQ-024 An all-zero instruction word SHALL be buffered and delivered like any other word.
REQ-025 Consecutive branch_taken cycles SHALL each redirect; the last one wins, and out_valid SHALL stay 0 throughout.

Reset
REQ-026 While rst=1, fetch_pc, pointers and count SHALL be 0, giving out_valid=0, buf_count=0 and imem_addr=0. out_instr and out_pc SHALL read 0.
REQ-027 Reset SHALL take effect immediately, independent of clk, including mid-operation with a full buffer or a concurrent branch.
REQ-028 At the first edge after rst deasserts, SHALL push address 0.

Verification
REQ-029 Release reset with out_ready=1 -> out_valid=1 from cycle 1; out_pc = 0,4,8,12,... one per cycle; out_instr matches memory.
REQ-030 Hold out_ready=0 for 5 cycles after reset -> buf_count=2, imem_addr held at 0x8; raise out_ready -> out_pc 0x0,0x4,0x8,0xC contiguous.
REQ-031 With count=2, pulse branch_taken for 1 cycle with branch_addr=0x43 -> next cycle out_valid=0, buf_count=0, imem_addr=0x40; following cycle out_pc=0x40.
REQ-032 Branch to 0xFFFFFFFC with out_ready=1 -> out_pc 0xFFFFFFFC, then 0x00000000.
REQ-033 Assert rst asynchronously between edges while count=2 -> out_valid, buf_count and imem_addr go to 0 before the next edge; after release, the sequence restarts at 0x0.
REQ-034 Alternate out_ready 1/0 every cycle for 20 cycles -> delivered out_pc sequence strictly +4 with no gaps or repeats.
